// File: rtl/acc_multicycle_cpu.sv
// rtl/acc_multicycle_cpu.sv - multi-cycle 8-bit accumulator-style CPU core with byte-wide fetch
// Optional HALT opcode enabled by defining CPU_HALT_EN; otherwise opcode F is a NOP.
module acc_multicycle_cpu #(
    parameter int DW   = 8,
    parameter int NREG = 4
) (
    input  logic          clk,
    input  logic          rst,
    output logic [DW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [DW-1:0] pc,
    output logic [2:0]    flags,
    output logic          halted,
    input  logic [1:0]    dbg_sel,
    output logic [DW-1:0] dbg_reg
);

    typedef enum logic [2:0] {
        S_F1, S_F2, S_DEC, S_EXE, S_MEM, S_WB, S_HALT
    } state_t;

    state_t          state, state_nx;
    logic [DW-1:0]   regs [NREG];
    logic [2*DW-1:0] ir;
    logic [DW-1:0]   a, b, res;
    logic [2:0]      res_flags;
    logic [DW:0]     alu;
    logic            jump_taken;

    logic [3:0]    op;
    logic [1:0]    rd, rs;
    logic [DW-1:0] imm;

    assign op  = ir[2*DW-1 -: 4];
    assign rd  = ir[2*DW-5 -: 2];
    assign rs  = ir[2*DW-7 -: 2];
    assign imm = ir[DW-1:0];

    assign dbg_reg = regs[dbg_sel];

    // flags = {C,Z,N}; jumps test the committed flags
    always_comb begin
        jump_taken = 1'b0;
        case (op)
            4'hA:    jump_taken = 1'b1;
            4'hB:    jump_taken = flags[1];
            4'hC:    jump_taken = flags[2];
            4'hD:    jump_taken = flags[0];
            default: jump_taken = 1'b0;
        endcase
    end

    // ADDI's immediate is latched into b at DEC, so it shares the ADD path
    always_comb begin
        alu = '0;
        case (op[2:0])
            3'd0, 3'd6: alu = {1'b0, a} + {1'b0, b};
            3'd1:       alu = {1'b0, a} - {1'b0, b};
            3'd2:       alu = {1'b0, a & b};
            3'd3:       alu = {1'b0, a | b};
            3'd4:       alu = {1'b0, a ^ b};
            3'd5:       alu = {1'b0, ~b};
            default:    alu = {1'b0, b};
        endcase
    end

    always_comb begin
        state_nx  = state;
        mem_addr  = pc;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_wdata = '0;
        case (state)
            S_F1: begin
                mem_rd   = rst;
                state_nx = S_F2;
            end
            S_F2: begin
                mem_rd   = rst;
                state_nx = S_DEC;
            end
            S_DEC: begin
                if (op <= 4'h7)
                    state_nx = S_EXE;
                else if (op == 4'h8 || op == 4'h9)
                    state_nx = S_MEM;
`ifdef CPU_HALT_EN
                else if (op == 4'hF)
                    state_nx = S_HALT;
`endif
                else
                    state_nx = S_F1;
            end
            S_EXE: state_nx = S_WB;
            S_MEM: begin
                mem_addr = imm;
                if (op == 4'h8) begin
                    mem_rd   = rst;
                    state_nx = S_WB;
                end else begin
                    mem_wr    = rst;
                    mem_wdata = rst ? a : '0;
                    state_nx  = S_F1;
                end
            end
            S_WB:    state_nx = S_F1;
            S_HALT:  state_nx = S_HALT;
            default: state_nx = S_F1;
        endcase
    end

`ifdef CPU_HALT_EN
    assign halted = (state == S_HALT);
`else
    assign halted = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_F1;
            pc        <= '0;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            res       <= '0;
            res_flags <= '0;
            flags     <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_F1: begin
                    ir[2*DW-1:DW] <= mem_rdata;
                    pc            <= pc + 1'b1;
                end
                S_F2: begin
                    ir[DW-1:0] <= mem_rdata;
                    pc         <= pc + 1'b1;
                end
                S_DEC: begin
                    a <= regs[rd];
                    b <= (op == 4'h6) ? imm : regs[rs];
                    if (jump_taken) pc <= imm;
                end
                S_EXE: begin
                    res       <= alu[DW-1:0];
                    res_flags <= {alu[DW], alu[DW-1:0] == '0, alu[DW-1]};
                end
                S_MEM: begin
                    if (op == 4'h8) res <= mem_rdata;
                end
                S_WB: begin
                    regs[rd] <= res;
                    if (op <= 4'h6) flags <= res_flags;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_multicycle_cpu.sv
// tb/tb_acc_multicycle_cpu.sv - directed self-checking bench for acc_multicycle_cpu
module tb_acc_multicycle_cpu;

    logic       clk;
    logic       rst;
    logic [7:0] mem_addr, mem_rdata, mem_wdata, pc, dbg_reg;
    logic       mem_rd, mem_wr, halted;
    logic [2:0] flags;
    logic [1:0] dbg_sel;
    logic [7:0] mem [256];
    logic [7:0] v;

    int checks = 0;
    int failures = 0;

    acc_multicycle_cpu dut (
        .clk(clk), .rst(rst),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr),
        .pc(pc), .flags(flags), .halted(halted),
        .dbg_sel(dbg_sel), .dbg_reg(dbg_reg)
    );

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic get_reg(input int i, output logic [7:0] val);
        dbg_sel = i[1:0];
        #1;
        val = dbg_reg;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        dbg_sel = 2'd0;
        clear_mem();

        // reset state
        tick(2);
        check("rst_pc", pc, 8'h00);
        check("rst_flags", flags, 3'b000);
        check("rst_mem_wr", mem_wr, 1'b0);
        check("rst_mem_rd", mem_rd, 1'b0);
        for (int r = 0; r < 4; r++) begin
            get_reg(r, v);
            check($sformatf("rst_r%0d", r), v, 8'h00);
        end
        rst = 1'b1;
        #1;
        check("rel_addr", mem_addr, 8'h00);
        check("rel_rd", mem_rd, 1'b1);

        // ADDI R1,0x7F ; ADDI R1,1 -> overflow into sign bit
        clear_mem();
        mem[0] = 8'h64; mem[1] = 8'h7F; mem[2] = 8'h64; mem[3] = 8'h01;
        do_reset();
        tick(9);
        get_reg(1, v);
        check("addi_r1_before", v, 8'h7F);
        tick(1);
        get_reg(1, v);
        check("addi_r1", v, 8'h80);
        check("addi_flags", flags, 3'b001);
        check("addi_pc", pc, 8'h04);

        // reset in WB aborts the pending register write
        do_reset();
        tick(4);
        rst = 1'b0;
        tick(1);
        get_reg(1, v);
        check("abort_r1", v, 8'h00);
        check("abort_pc", pc, 8'h00);
        rst = 1'b1;

        // carry/zero then MOV keeps flags
        clear_mem();
        mem[0] = 8'h68; mem[1] = 8'hFF; mem[2] = 8'h68; mem[3] = 8'h01;
        mem[4] = 8'h7E; mem[5] = 8'h00;
        do_reset();
        tick(10);
        get_reg(2, v);
        check("cz_r2", v, 8'h00);
        check("cz_flags", flags, 3'b110);
        tick(5);
        get_reg(3, v);
        check("mov_r3", v, 8'h00);
        check("mov_flags", flags, 3'b110);

        // LOAD R0,0x40 ; STORE R0,0x41
        clear_mem();
        mem[0] = 8'h80; mem[1] = 8'h40; mem[2] = 8'h90; mem[3] = 8'h41;
        mem[8'h40] = 8'h5A;
        do_reset();
        tick(5);
        get_reg(0, v);
        check("load_r0", v, 8'h5A);
        check("load_flags", flags, 3'b000);
        tick(2);
        check("store_wr_early", mem_wr, 1'b0);
        tick(1);
        check("store_wr", mem_wr, 1'b1);
        check("store_addr", mem_addr, 8'h41);
        check("store_data", mem_wdata, 8'h5A);
        tick(1);
        check("store_wr_end", mem_wr, 1'b0);
        check("store_mem", mem[8'h41], 8'h5A);
        check("store_pc", pc, 8'h04);

        // SUB R1,R1 ; JZ 0x20 -> taken
        clear_mem();
        mem[0] = 8'h15; mem[1] = 8'h00; mem[2] = 8'hB0; mem[3] = 8'h20;
        do_reset();
        tick(5);
        check("sub_z_flags", flags, 3'b010);
        tick(2);
        check("jz_pc_mid", pc, 8'h04);
        tick(1);
        check("jz_taken_pc", pc, 8'h20);

        // ADDI R1,1 ; JZ 0x20 -> not taken
        clear_mem();
        mem[0] = 8'h64; mem[1] = 8'h01; mem[2] = 8'hB0; mem[3] = 8'h20;
        do_reset();
        tick(8);
        check("jz_fall_pc", pc, 8'h04);

        // ADDI R1,5 ; SUB R0,R1 (borrow) ; JC 0x30
        clear_mem();
        mem[0] = 8'h64; mem[1] = 8'h05; mem[2] = 8'h11; mem[3] = 8'h00;
        mem[4] = 8'hC0; mem[5] = 8'h30;
        do_reset();
        tick(10);
        get_reg(0, v);
        check("sub_borrow_r0", v, 8'hFB);
        check("sub_borrow_flags", flags, 3'b101);
        tick(3);
        check("jc_taken_pc", pc, 8'h30);

        // opcode F followed by ADDI R1,7
        clear_mem();
        mem[0] = 8'hF0; mem[1] = 8'h00; mem[2] = 8'h64; mem[3] = 8'h07;
        do_reset();
`ifdef CPU_HALT_EN
        tick(3);
        check("halt_flag", halted, 1'b1);
        check("halt_pc", pc, 8'h02);
        tick(20);
        check("halt_pc_frozen", pc, 8'h02);
        check("halt_still", halted, 1'b1);
        check("halt_no_rd", mem_rd, 1'b0);
`else
        tick(3);
        check("nop_pc", pc, 8'h02);
        tick(5);
        get_reg(1, v);
        check("nop_next_r1", v, 8'h07);
        check("nop_halted", halted, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/acc_multicycle_cpu.md
Name: acc_multicycle_cpu

Overview:
- Multi-cycle 8-bit CPU core: datapath plus FSM controller in one block.
- Fetches 16-bit instructions as two bytes from an external byte-wide memory.
- Executes on a 4-entry register file with C/Z/N flags.
- Top-level compute block; memory lives outside and is read combinationally.

Parameters:
- DW, 8, data/register width (spec is written for 8; address width equals DW).
- NREG, 4, register-file entries (2-bit register fields).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- mem_addr  out  8  memory byte address.
- mem_rdata  in  8  read data; combinational from mem_addr, same cycle.
- mem_wdata  out  8  store data.
- mem_rd  out  1  read strobe.
- mem_wr  out  1  write strobe; memory writes on clk edge while high.
- pc  out  8  current program counter.
- flags  out  3  {C,Z,N}.
- halted  out  1  core stopped.
- dbg_sel  in  2  register-file debug read select.
- dbg_reg  out  8  R[dbg_sel], combinational.

Behaviour:
- Instruction encoding: byte0 = {op[3:0], rd[1:0], rs[1:0]}; byte1 = imm8/addr8. PC increments by 1 per byte and wraps 0xFF->0x00.
- Reset (rst=0 at edge): PC=0, R0-R3=0, C=Z=N=0, IR=0, state=F1, halted=0. mem_rd, mem_wr and mem_wdata are 0 while in reset.
- States: F1, F2, DEC, EXE, MEM, WB, HALT.
- F1: mem_addr=PC, mem_rd=1, IR[15:8]<=mem_rdata, PC+1.
- F2: same, IR[7:0]<=mem_rdata, PC+1.
- DEC: operands latched into A/B registers. Then goes to:
  - EXE for op 0-7.
  - MEM for op 8-9.
  - F1 for jumps, NOP and undefined opcodes.
- Opcodes (ALU op is 3-bit):
  - 0 ADD: rd=rd+rs.
  - 1 SUB: rd=rd-rs; C=borrow (1 when rd<rs unsigned).
  - 2 AND, 3 OR, 4 XOR: C<=0.
  - 5 NOT: rd=~rs; C<=0.
  - 6 ADDI: rd=rd+imm8.
  - 7 MOV: rd=rs; flags unchanged.
  - 8 LOAD: rd=mem[addr8].
  - 9 STORE: mem[addr8]=rd.
  - A JMP: PC=addr8.
  - B JZ, C JC, D JN: PC=addr8 if the flag is set, else fall through.
  - E NOP.
  - F HALT (see optional feature).
- ADD/ADDI: C = carry out of bit 7. Ops 0-6: Z = (result==0), N = result[7].
- LOAD, STORE and MOV never change flags.
- EXE: ALU result into result register; go to WB.
- MEM, LOAD: mem_rd=1, data register <= mem_rdata; go to WB.
- MEM, STORE: mem_wr=1, mem_wdata=R[rd] for exactly one cycle; go to F1.
- WB: register write and flag update on the same edge; go to F1.
- Cycle counts:
  - ALU/ADDI/MOV/LOAD: 5 cycles (F1, F2, DEC, EXE|MEM, WB).
  - STORE: 4 cycles.
  - Jumps/NOP: 3 cycles.
- Jump resolution: taken jumps load PC at the DEC edge. Flags tested are those committed by earlier instructions.
- rd==rs is legal; both reads take the pre-write value.
- Reset asserted mid-instruction aborts it. No partial register or memory write happens on the reset edge.
- Simultaneous events: only one register write per instruction, so no write conflicts.

Optional Feature:
- Macro CPU_HALT_EN.
- Defined: opcode F in DEC enters HALT. In HALT, halted=1, no memory strobes, PC frozen. Only reset exits.
- Undefined: opcode F behaves as NOP; halted is tied 0.

Test Plan:
- Reset: run with rst=0 for 2 cycles -> pc=0x00, all dbg_reg=0x00, flags=000, mem_wr=0. After release, mem_addr=0x00 and mem_rd=1 on the first cycle.
- ADDI overflow into sign: memory 0x64,0x7F,0x64,0x01 (ADDI R1,0x7F; ADDI R1,1) -> R1=0x80, N=1, Z=0, C=0. Second instruction completes 10 cycles after reset release.
- Carry/zero plus MOV: ADDI R2,0xFF; ADDI R2,0x01 -> R2=0x00, C=1, Z=1, N=0. Then MOV R3,R2 -> R3=0x00 with flags still 110 (C,Z,N).
- LOAD/STORE: mem[0x40]=0x5A; LOAD R0,0x40 (0x80,0x40); STORE R0,0x41 (0x90,0x41) -> single-cycle mem_wr at addr 0x41 with data 0x5A; R0=0x5A.
- Branches: SUB R1,R1 (Z=1) then JZ 0x20 (0xB0,0x20) -> pc=0x20 three cycles after the JZ fetch start. With Z=0, pc = JZ address + 2.
- HALT: with CPU_HALT_EN, opcode 0xF0 -> halted=1 and pc frozen for 20 cycles. Without the macro, execution continues at the next instruction.
